// File: rtl/systolic_skew_feeder_if.sv
// Write port and skewed edge-operand bus between the matrix loader, the
// skew feeder and the systolic array edges.
interface systolic_skew_feeder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic                    wr_en;
    logic                    wr_sel;
    logic [IW-1:0]           wr_row;
    logic [IW-1:0]           wr_col;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    start;
    logic                    busy;
    logic [N*DATA_WIDTH-1:0] a_out;
    logic [N*DATA_WIDTH-1:0] b_out;
    logic                    feed_valid;
    logic                    done;

    modport master (
        output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        input  busy, a_out, b_out, feed_valid, done
    );

    modport slave (
        input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        output busy, a_out, b_out, feed_valid, done
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Holds one A and one B matrix and streams them onto the west/north edges of
// an N x N output-stationary array with row/column diagonal skew.
module systolic_skew_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4,
    parameter int MULT_LAT   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    systolic_skew_feeder_if.slave   bus
);
    localparam int CNT_W = $clog2(2*N + MULT_LAT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FEED  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(2*N - 2);
    localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(N + MULT_LAT - 1);

    logic [1:0]              state_r;
    logic [CNT_W-1:0]        t_r;
    logic                    busy_r;
    logic                    feed_valid_r;
    logic                    done_r;
    logic [N*DATA_WIDTH-1:0] a_out_r;
    logic [N*DATA_WIDTH-1:0] b_out_r;

    logic [DATA_WIDTH-1:0]   a_mem_r [N][N];
    logic [DATA_WIDTH-1:0]   b_mem_r [N][N];
    logic [DATA_WIDTH-1:0]   a_eff_s [N][N];
    logic [DATA_WIDTH-1:0]   b_eff_s [N][N];

    logic                    wr_ok_s;
    logic [CNT_W-1:0]        nt_s;
    logic [N*DATA_WIDTH-1:0] a_next_s;
    logic [N*DATA_WIDTH-1:0] b_next_s;

    // Store view with any accepted write merged in, so beat 0 sees a same-cycle write.
    always_comb begin
        wr_ok_s = bus.wr_en && (state_r == ST_IDLE)
                  && (int'(bus.wr_row) < N) && (int'(bus.wr_col) < N);
        a_eff_s = a_mem_r;
        b_eff_s = b_mem_r;
        if (wr_ok_s && !bus.wr_sel) begin
            a_eff_s[bus.wr_row][bus.wr_col] = bus.wr_data;
        end else if (wr_ok_s) begin
            b_eff_s[bus.wr_row][bus.wr_col] = bus.wr_data;
        end else begin
            a_eff_s = a_mem_r;
        end
    end

    // Skew selection: lane i carries the element whose row+col index equals the next beat.
    always_comb begin
        nt_s     = (state_r == ST_IDLE) ? '0 : t_r + CNT_W'(1);
        a_next_s = '0;
        b_next_s = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                a_next_s[i*DATA_WIDTH +: DATA_WIDTH] = (i + k == int'(nt_s)) ?
                    a_eff_s[i][k] : a_next_s[i*DATA_WIDTH +: DATA_WIDTH];
                b_next_s[i*DATA_WIDTH +: DATA_WIDTH] = (i + k == int'(nt_s)) ?
                    b_eff_s[k][i] : b_next_s[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Matrix store: cleared by reset, otherwise follows the merged write view.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    a_mem_r[i][k] <= '0;
                    b_mem_r[i][k] <= '0;
                end
            end
        end else begin
            a_mem_r <= a_eff_s;
            b_mem_r <= b_eff_s;
        end
    end

    // Pass sequencer: t_r counts skew beats in FEED and drain cycles in DRAIN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            t_r          <= '0;
            busy_r       <= 1'b0;
            feed_valid_r <= 1'b0;
            done_r       <= 1'b0;
            a_out_r      <= '0;
            b_out_r      <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    t_r    <= '0;
                    if (bus.start) begin
                        state_r      <= ST_FEED;
                        busy_r       <= 1'b1;
                        feed_valid_r <= 1'b1;
                        a_out_r      <= a_next_s;
                        b_out_r      <= b_next_s;
                    end else begin
                        busy_r       <= 1'b0;
                        feed_valid_r <= 1'b0;
                        a_out_r      <= '0;
                        b_out_r      <= '0;
                    end
                end
                ST_FEED: begin
                    if (t_r == LAST_BEAT) begin
                        state_r      <= ST_DRAIN;
                        t_r          <= '0;
                        feed_valid_r <= 1'b0;
                        a_out_r      <= '0;
                        b_out_r      <= '0;
                    end else begin
                        t_r          <= t_r + CNT_W'(1);
                        a_out_r      <= a_next_s;
                        b_out_r      <= b_next_s;
                    end
                end
                ST_DRAIN: begin
                    if (t_r == LAST_DRAIN) begin
                        state_r <= ST_IDLE;
                        t_r     <= '0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        t_r     <= t_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    t_r          <= '0;
                    busy_r       <= 1'b0;
                    feed_valid_r <= 1'b0;
                    done_r       <= 1'b0;
                    a_out_r      <= '0;
                    b_out_r      <= '0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.feed_valid = feed_valid_r;
    assign bus.done       = done_r;
    assign bus.a_out      = a_out_r;
    assign bus.b_out      = b_out_r;
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Randomized self-checking bench for systolic_skew_feeder against a matrix-level
// model of the skewed beats, pass timing and a behavioural PE array.
module tb_systolic_skew_feeder;
    localparam int DW     = 8;
    localparam int N      = 4;
    localparam int ML     = 2;
    localparam int DONE_T = (2*N - 1) + (N + ML);

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    int   ma [N][N];
    int   mb [N][N];

    // Behavioural PE array fed from the DUT edges.
    int   pa [N][N];
    int   pb [N][N];
    int   pain [N][N];
    int   pbin [N][N];
    int   p1 [N][N];
    int   p2 [N][N];
    int   acc [N][N];
    bit   pe_clr;
    bit   pe_check;

    systolic_skew_feeder_if #(.DATA_WIDTH(DW), .N(N)) bus ();

    systolic_skew_feeder #(.DATA_WIDTH(DW), .N(N), .MULT_LAT(ML)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                pain[i][j] = (j == 0) ? int'(bus.a_out[i*DW +: DW]) : pa[i][(j+N-1)%N];
                pbin[i][j] = (i == 0) ? int'(bus.b_out[j*DW +: DW]) : pb[(i+N-1)%N][j];
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                pa[i][j]  <= pain[i][j];
                pb[i][j]  <= pbin[i][j];
                p1[i][j]  <= pain[i][j] * pbin[i][j];
                p2[i][j]  <= p1[i][j];
                acc[i][j] <= pe_clr ? 0 : acc[i][j] + p2[i][j];
            end
        end
    end

    task automatic write_elem(input bit sel, input int r, input int c, input int d);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_row  = r[1:0];
        bus.wr_col  = c[1:0];
        bus.wr_data = d[7:0];
        @(posedge clk);
        #1 bus.wr_en = 1'b0;
    endtask

    task automatic load_all();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                write_elem(1'b0, r, c, ma[r][c]);
                write_elem(1'b1, r, c, mb[r][c]);
            end
        end
    endtask

    task automatic set_pattern();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                ma[r][c] = 4*r + c + 1;
                mb[r][c] = 16 + 4*r + c;
            end
        end
    endtask

    // One pass from start acceptance through done; optional mid-pass injection or reset.
    task automatic run_pass(input bit hold, input int inject_t, input int reset_t);
        logic [N*DW-1:0] ea;
        logic [N*DW-1:0] eb;
        logic            efv;
        if (bus.start !== 1'b1) begin
            @(negedge clk);
            bus.start = 1'b1;
        end
        for (int t = 0; t <= DONE_T; t++) begin
            @(negedge clk);
            if (t == 0) begin
                bus.start = hold;
                bus.wr_en = 1'b0;
            end
            if (t == inject_t + 1) begin
                bus.start = 1'b0;
                bus.wr_en = 1'b0;
            end
            efv = (t <= 2*N - 2);
            ea  = '0;
            eb  = '0;
            for (int i = 0; i < N; i++) begin
                if (efv && t - i >= 0 && t - i < N) begin
                    ea[i*DW +: DW] = ma[i][t-i][7:0];
                    eb[i*DW +: DW] = mb[t-i][i][7:0];
                end
            end
            checks += 5;
            if (bus.a_out !== ea) begin
                failures++;
                $display("FAIL a_out t=%0d got=%h exp=%h", t, bus.a_out, ea);
            end
            if (bus.b_out !== eb) begin
                failures++;
                $display("FAIL b_out t=%0d got=%h exp=%h", t, bus.b_out, eb);
            end
            if (bus.feed_valid !== efv) begin
                failures++;
                $display("FAIL feed_valid t=%0d got=%b exp=%b", t, bus.feed_valid, efv);
            end
            if (bus.busy !== (t < DONE_T)) begin
                failures++;
                $display("FAIL busy t=%0d got=%b exp=%b", t, bus.busy, t < DONE_T);
            end
            if (bus.done !== (t == DONE_T)) begin
                failures++;
                $display("FAIL done t=%0d got=%b exp=%b", t, bus.done, t == DONE_T);
            end
            if (pe_check && t == DONE_T) begin
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        checks++;
                        if (acc[i][j] != mb[i][j]) begin
                            failures++;
                            $display("FAIL pe_c[%0d][%0d] got=%0d exp=%0d", i, j, acc[i][j], mb[i][j]);
                        end
                    end
                end
            end
            if (t == inject_t) begin
                bus.start   = 1'b1;
                bus.wr_en   = 1'b1;
                bus.wr_sel  = 1'b0;
                bus.wr_row  = 2'd0;
                bus.wr_col  = 2'd0;
                bus.wr_data = 8'd99;
            end
            if (t == reset_t) begin
                rst = 1'b0;
                #1;
                checks++;
                if ({bus.a_out, bus.b_out, bus.feed_valid, bus.busy, bus.done} !== '0) begin
                    failures++;
                    $display("FAIL reset_mid got=%h exp=0", {bus.a_out, bus.b_out, bus.feed_valid, bus.busy, bus.done});
                end
                @(negedge clk);
                rst = 1'b1;
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        ma[r][c] = 0;
                        mb[r][c] = 0;
                    end
                end
                return;
            end
        end
        if (!hold) begin
            @(negedge clk);
            checks++;
            if ({bus.feed_valid, bus.busy, bus.done} !== 3'b000) begin
                failures++;
                $display("FAIL after_done got=%b exp=000", {bus.feed_valid, bus.busy, bus.done});
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.a_out, bus.b_out, bus.feed_valid, bus.busy, bus.done} !== '0) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d got=%h exp=0", c,
                         {bus.a_out, bus.b_out, bus.feed_valid, bus.busy, bus.done});
            end
        end
    endtask

    task automatic test_skew();
        set_pattern();
        load_all();
        run_pass(1'b0, -1, -1);
    endtask

    task automatic test_busy_protect();
        run_pass(1'b0, 2, -1);
        run_pass(1'b0, -1, -1);
    endtask

    task automatic test_random();
        for (int p = 0; p < 3; p++) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    ma[r][c] = int'($urandom_range(0, 255));
                    mb[r][c] = int'($urandom_range(0, 255));
                end
            end
            load_all();
            // Same-cycle write and start: the write must reach beat 0.
            ma[0][0] = int'($urandom_range(0, 255));
            @(negedge clk);
            bus.wr_en   = 1'b1;
            bus.wr_sel  = 1'b0;
            bus.wr_row  = 2'd0;
            bus.wr_col  = 2'd0;
            bus.wr_data = ma[0][0][7:0];
            bus.start   = 1'b1;
            run_pass(1'b0, -1, -1);
        end
    endtask

    task automatic test_back_to_back();
        run_pass(1'b1, -1, -1);
        run_pass(1'b0, -1, -1);
    endtask

    task automatic test_pe_array();
        set_pattern();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                ma[r][c] = (r == c) ? 1 : 0;
            end
        end
        load_all();
        @(negedge clk);
        pe_clr = 1'b1;
        @(negedge clk);
        pe_clr   = 1'b0;
        pe_check = 1'b1;
        run_pass(1'b0, -1, -1);
        pe_check = 1'b0;
    endtask

    task automatic test_reset_mid();
        set_pattern();
        load_all();
        run_pass(1'b0, -1, 3);
        run_pass(1'b0, -1, -1);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        pe_clr      = 1'b0;
        pe_check    = 1'b0;
        rst         = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_sel  = 1'b0;
        bus.wr_row  = '0;
        bus.wr_col  = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        test_reset();
        test_skew();
        test_busy_protect();
        test_random();
        test_back_to_back();
        test_pe_array();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Operand feeder for the N×N output-stationary systolic array. It holds one N×N A matrix and one N×N B matrix, loaded through a simple write port. On `start` it drives the array's west edge (A rows) and north edge (B columns) with the diagonal skew that processing elements need: row i is delayed i cycles and column j is delayed j cycles. After the last operand it waits until the far-corner PE has accumulated, then pulses `done`. It is the transmitting end of the PE operand interface and sits between the matrix buffer and the array edges.

## Interface
- `DATA_WIDTH`, 8, operand width in bits.
- `N`, 4, array dimension (rows = columns), N ≥ 2.
- `MULT_LAT`, 2, PE multiplier latency in cycles, from operand at PE input to product available to the accumulator.
- `clk` input 1: single clock, all state on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `wr_en` input 1: write strobe for the matrix store.
- `wr_sel` input 1: 0 writes A, 1 writes B.
- `wr_row` input $clog2(N): row index of the write.
- `wr_col` input $clog2(N): column index of the write.
- `wr_data` input DATA_WIDTH: element value.
- `start` input 1: begin a feed pass; level-sampled.
- `busy` output 1: high from start acceptance until the `done` edge.
- `a_out` output N*DATA_WIDTH: west-edge operands; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH] drives row i.
- `b_out` output N*DATA_WIDTH: north-edge operands; lane j drives column j.
- `feed_valid` output 1: high while a skew beat (t = 0..2N-2) is on the outputs.
- `done` output 1: one-cycle pulse when the pass is complete.

## Operation
- States: IDLE, FEED, DRAIN.
- IDLE:
  - A write with `wr_en`=1 stores `wr_data` into A[wr_row][wr_col] or B[wr_row][wr_col].
  - Writes with an index ≥ N are ignored.
  - Outputs are zero.
- IDLE → FEED when `start`=1. The same edge clears beat counter t to 0 and registers beat 0.
- FEED, beat t (0 ≤ t ≤ 2N-2):
  - `a_out` lane i = A[i][t-i] if 0 ≤ t-i < N, else 0.
  - `b_out` lane j = B[t-j][j] if 0 ≤ t-j < N, else 0.
- After beat 2N-2: FEED → DRAIN. Outputs go to 0 and `feed_valid` goes to 0.
- DRAIN lasts N+MULT_LAT cycles. This is N-1 hops for the last operand to reach PE(N-1,N-1), plus MULT_LAT, plus one accumulate. The zero operands keep PE accumulators unchanged.
- At the end of DRAIN: `done`=1 for one cycle, `busy`=0, state → IDLE.
- `start` is ignored while busy. `wr_en` is ignored while busy, so the store is stable during a pass.
- Matrix contents persist across passes and are not cleared by `done`.
- Reset (any time, including mid-FEED or mid-DRAIN):
  - State → IDLE; t=0.
  - `a_out`, `b_out`, `feed_valid`, `busy`, `done` all 0.
  - Matrix store cleared to 0.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Let E0 be the edge that samples `start`=1 in IDLE.
  - Beat t is visible in the cycle after edge E0+t.
  - `busy` and `feed_valid` rise after E0.
- `feed_valid` falls after edge E0+2N-1.
- `done` is high in the cycle after edge E0+(2N-1)+(N+MULT_LAT). `busy` falls on that same edge.
  - Defaults: 7+6 = 13 edges after E0.
- `start` held high through `done` starts a new pass on the edge after `done`. It is accepted only once the state is back in IDLE.
- A write in the same cycle as accepted `start` takes effect before beat 0 is registered.

## Test plan
- Reset values: deassert `rst` with inputs idle → all outputs 0, and they stay 0 for 10 cycles.
- Skew beats (defaults): load A[i][k]=4i+k+1 and B[k][j]=16+4k+j, then start.
  - Beat 0: `a_out` lanes {1,0,0,0}, `b_out` lanes {16,0,0,0}.
  - Beat 3: `a_out` lanes {4,7,10,13}, `b_out` lanes {28,25,22,19}.
  - Beat 6: `a_out` lanes {0,0,0,16}, `b_out` lanes {0,0,0,31}.
- Done latency (defaults): `done` pulses exactly 13 edges after E0 and lasts one cycle. `feed_valid` is high for exactly 7 cycles.
- Integrated with a 4×4 PE array: A = identity and B as above → each PE result C[i][j] equals B[i][j] at `done`.
- Busy protection: mid-FEED, pulse `start` and write A[0][0]=99 → the pass is unchanged. A second pass then shows A[0][0]=1.
- Reset mid-FEED at beat 3 → all outputs 0 next cycle and the store is zeroed. A subsequent start feeds all zeros and `done` arrives after 13 edges.
